bank_regctl: RTL and testbench

//   Owns the four 16KB bank registers that map the Z80 address space onto flash, cartridge and RAM.

---
 rtl/bank_regctl_if.sv | 39 +++
 rtl/bank_regctl.sv | 122 ++++++++++++
 tb/tb_bank_regctl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_regctl_if.sv
// Bus bundle for bank_regctl: Z80 pins, SPI register-write port, IO readback
// and the memory-mapping outputs.
//   slave  : seen from bank_regctl (bus and SPI inputs, mapping/readback outputs)
//   master : seen from the driver of the Z80 bus and the SPI slave
interface bank_regctl_if;
    logic [15:0] bus_a;
    logic [7:0]  bus_wrdata;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_mreq_n;
    logic        bus_iorq_n;

    logic        spi_wr_req;
    logic [1:0]  spi_wr_sel;
    logic [7:0]  spi_wr_data;
    logic        spi_wr_ack;

    logic [7:0]  rddata;
    logic        rddata_oe;
    logic [4:0]  bus_ba;
    logic        ram_ce_n;
    logic        rom_ce_n;
    logic        cart_ce_n;
    logic [31:0] bank_regs;

    modport slave (
        input  bus_a, bus_wrdata, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n,
        input  spi_wr_req, spi_wr_sel, spi_wr_data,
        output spi_wr_ack, rddata, rddata_oe, bus_ba,
        output ram_ce_n, rom_ce_n, cart_ce_n, bank_regs
    );

    modport master (
        output bus_a, bus_wrdata, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n,
        output spi_wr_req, spi_wr_sel, spi_wr_data,
        input  spi_wr_ack, rddata, rddata_oe, bus_ba,
        input  ram_ce_n, rom_ce_n, cart_ce_n, bank_regs
    );
endinterface

// File: rtl/bank_regctl.sv
// bank_regctl: four 16KB bank registers mapping the Z80 address space onto
// flash, cartridge and RAM.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : bank_regctl_if.slave
//           - Z80 IO writes (synchronised) and SPI writes update the registers,
//             Z80 having priority; SPI write acknowledged with a 1-cycle pulse
//           - rddata/rddata_oe: combinational IO readback of the registers
//           - bus_ba, *_ce_n: combinational banked address and chip selects
//           - bank_regs: {bank3,bank2,bank1,bank0}
module bank_regctl #(
    parameter logic [7:0] IO_BASE   = 8'hF0,
    parameter logic [7:0] RST_BANK0 = 8'h80,
    parameter logic [7:0] RST_BANK1 = 8'h21,
    parameter logic [7:0] RST_BANK2 = 8'h22,
    parameter logic [7:0] RST_BANK3 = 8'h23
) (
    input  logic          clk,
    input  logic          reset,
    bank_regctl_if.slave  bus
);

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned REG_W     = 8;

    logic [NUM_BANKS-1:0][REG_W-1:0] bank_q, bank_d;
    logic                            ack_q, ack_d;

    logic iowr_c;
    logic iowr_s1, iowr_s2, iowr_s3;
    logic commit_c;
    logic port_hit_c;

    logic [REG_W-1:0] sel_c;
    logic             wp_block_c;
    logic             ram_ce_n_c, rom_ce_n_c, cart_ce_n_c;

    // Address bits 13:8 play no part in decode or mapping.
    logic unused_bus_a;
    assign unused_bus_a = ^bus.bus_a[13:8];

    // Z80 IO write strobe, asynchronous to clk.
    assign iowr_c     = !bus.bus_iorq_n && !bus.bus_wr_n;
    assign port_hit_c = (bus.bus_a[7:2] == IO_BASE[7:2]);

    // Two-flop synchroniser plus edge register; a commit lands on the 3rd clock
    // after the strobe, address and data having been stable for several clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iowr_s1 <= 1'b0;
            iowr_s2 <= 1'b0;
            iowr_s3 <= 1'b0;
        end else begin
            iowr_s1 <= iowr_c;
            iowr_s2 <= iowr_s1;
            iowr_s3 <= iowr_s2;
        end
    end

    assign commit_c = iowr_s2 && !iowr_s3;

    // Register write arbitration: a Z80 commit (any port) blocks SPI for that
    // cycle; the held SPI request then lands on the following cycle.
    always_comb begin
        bank_d = bank_q;
        ack_d  = 1'b0;
        if (commit_c) begin
            if (port_hit_c) begin
                bank_d[bus.bus_a[1:0]] = bus.bus_wrdata;
            end
        end else if (bus.spi_wr_req) begin
            bank_d[bus.spi_wr_sel] = bus.spi_wr_data;
            ack_d                  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0] <= RST_BANK0;
            bank_q[1] <= RST_BANK1;
            bank_q[2] <= RST_BANK2;
            bank_q[3] <= RST_BANK3;
            ack_q     <= 1'b0;
        end else begin
            bank_q <= bank_d;
            ack_q  <= ack_d;
        end
    end

    // Memory mapping from the register selected by A15..A14.
    assign sel_c      = bank_q[bus.bus_a[15:14]];
    assign wp_block_c = sel_c[7] && !bus.bus_wr_n;

    // Page 0-15 flash, 16-31 cartridge, 32-63 RAM.
    always_comb begin
        ram_ce_n_c  = 1'b1;
        rom_ce_n_c  = 1'b1;
        cart_ce_n_c = 1'b1;
        if (!bus.bus_mreq_n && !wp_block_c) begin
            if (sel_c[5]) begin
                ram_ce_n_c = 1'b0;
            end else if (sel_c[4]) begin
                cart_ce_n_c = 1'b0;
            end else begin
                rom_ce_n_c = 1'b0;
            end
        end
    end

    assign bus.bus_ba     = sel_c[4:0];
    assign bus.ram_ce_n   = ram_ce_n_c;
    assign bus.rom_ce_n   = rom_ce_n_c;
    assign bus.cart_ce_n  = cart_ce_n_c;

    // IO readback, combinational.
    assign bus.rddata_oe  = !bus.bus_iorq_n && !bus.bus_rd_n && port_hit_c;
    assign bus.rddata     = bank_q[bus.bus_a[1:0]];

    assign bus.spi_wr_ack = ack_q;
    assign bus.bank_regs  = bank_q;

endmodule

// File: tb/tb_bank_regctl.sv
// Randomised self-checking bench for bank_regctl against a behavioural model
// of the four bank registers.
module tb_bank_regctl;

    localparam logic [7:0] IO_BASE = 8'hF0;

    logic clk;
    logic reset;

    bank_regctl_if bif ();

    bank_regctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_regs();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic model_reset();
        m[0] = 8'h80; m[1] = 8'h21; m[2] = 8'h22; m[3] = 8'h23;
    endtask

    function automatic bit is_io_port(input logic [7:0] port);
        return (int'(port) >= int'(IO_BASE)) && (int'(port) <= int'(IO_BASE) + 3);
    endfunction

    task automatic bus_idle();
        bif.bus_rd_n   = 1'b1;
        bif.bus_wr_n   = 1'b1;
        bif.bus_mreq_n = 1'b1;
        bif.bus_iorq_n = 1'b1;
    endtask

    // Z80 OUT: value must appear exactly after the 3rd rising clock.
    task automatic z80_out(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        bif.bus_a      = {8'($urandom), port};
        bif.bus_wrdata = data;
        bif.bus_iorq_n = 1'b0;
        bif.bus_wr_n   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("out_before_commit", bif.bank_regs, model_regs());
        @(negedge clk);
        if (is_io_port(port)) m[port - IO_BASE] = data;
        check("out_commit", bif.bank_regs, model_regs());
        repeat (5) @(negedge clk);
        bus_idle();
        repeat (4) @(negedge clk);
        check("out_settled", bif.bank_regs, model_regs());
    endtask

    task automatic spi_write(input logic [1:0] sel, input logic [7:0] data);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        bif.spi_wr_req  = 1'b1;
        bif.spi_wr_sel  = sel;
        bif.spi_wr_data = data;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (bif.spi_wr_ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("spi_ack_latency", 32'(lat), 32'd1);
        if (got) m[sel] = data;
        bif.spi_wr_req = 1'b0;
        check("spi_write", bif.bank_regs, model_regs());
        @(negedge clk);
        check("spi_ack_pulse", 32'(bif.spi_wr_ack), 32'd0);
    endtask

    // Z80 commit and SPI request in the same cycle on the same register.
    task automatic collide(input logic [1:0] sel, input logic [7:0] zdata, input logic [7:0] sdata);
        @(negedge clk);
        bif.bus_a      = {8'h00, IO_BASE + 8'(sel)};
        bif.bus_wrdata = zdata;
        bif.bus_iorq_n = 1'b0;
        bif.bus_wr_n   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bif.spi_wr_req  = 1'b1;
        bif.spi_wr_sel  = sel;
        bif.spi_wr_data = sdata;
        @(negedge clk);
        m[sel] = zdata;
        check("col_z80_first", bif.bank_regs, model_regs());
        check("col_no_ack", 32'(bif.spi_wr_ack), 32'd0);
        @(negedge clk);
        m[sel] = sdata;
        check("col_spi_final", bif.bank_regs, model_regs());
        check("col_ack", 32'(bif.spi_wr_ack), 32'd1);
        bif.spi_wr_req = 1'b0;
        @(negedge clk);
        check("col_ack_single", 32'(bif.spi_wr_ack), 32'd0);
        repeat (3) @(negedge clk);
        bus_idle();
        repeat (4) @(negedge clk);
        check("col_settled", bif.bank_regs, model_regs());
    endtask

    task automatic z80_in(input logic [7:0] port);
        @(negedge clk);
        bif.bus_a      = {8'($urandom), port};
        bif.bus_iorq_n = 1'b0;
        bif.bus_rd_n   = 1'b0;
        #1;
        check("in_oe", 32'(bif.rddata_oe), 32'(is_io_port(port)));
        if (is_io_port(port)) check("in_data", 32'(bif.rddata), 32'(m[port - IO_BASE]));
        @(negedge clk);
        bus_idle();
        #1;
        check("in_oe_idle", 32'(bif.rddata_oe), 32'd0);
    endtask

    // Memory access: expected selects derived from page ranges and WP.
    task automatic mem_access(input logic [15:0] addr, input bit is_wr);
        logic [7:0] r;
        int         page;
        logic [2:0] exp_ce;
        r      = m[addr / 16'h4000];
        page   = int'(r) % 64;
        exp_ce = 3'b111;
        if (!(r[7] && is_wr)) begin
            if (page < 16)      exp_ce = 3'b101;
            else if (page < 32) exp_ce = 3'b110;
            else                exp_ce = 3'b011;
        end
        @(negedge clk);
        bif.bus_a      = addr;
        bif.bus_mreq_n = 1'b0;
        bif.bus_rd_n   = is_wr;
        bif.bus_wr_n   = !is_wr;
        #1;
        check("mem_ce", 32'({bif.ram_ce_n, bif.rom_ce_n, bif.cart_ce_n}), 32'(exp_ce));
        check("mem_ba", 32'(bif.bus_ba), 32'(page % 32));
        @(negedge clk);
        bus_idle();
        #1;
        check("mem_ce_idle", 32'({bif.ram_ce_n, bif.rom_ce_n, bif.cart_ce_n}), 32'd7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] port;
        bus_idle();
        bif.bus_a       = 16'h0000;
        bif.bus_wrdata  = 8'h00;
        bif.spi_wr_req  = 1'b0;
        bif.spi_wr_sel  = 2'd0;
        bif.spi_wr_data = 8'h00;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_regs", bif.bank_regs, 32'h23222180);
        check("reset_ack", 32'(bif.spi_wr_ack), 32'd0);
        mem_access(16'h0000, 1'b0);

        z80_out(8'hF1, 8'h25);
        mem_access(16'h4000, 1'b0);

        collide(2'd2, 8'h11, 8'h30);

        spi_write(2'd3, 8'hA4);
        mem_access(16'hC000, 1'b1);
        mem_access(16'hC000, 1'b0);

        z80_in(8'hF3);
        z80_in(8'hF4);
        z80_out(8'h3F, 8'h77);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    port = ($urandom_range(0, 1) != 0) ? IO_BASE + 8'($urandom_range(0, 3))
                                                       : 8'($urandom);
                    z80_out(port, 8'($urandom));
                end
                1: spi_write(2'($urandom), 8'($urandom));
                2: z80_in(($urandom_range(0, 1) != 0) ? IO_BASE + 8'($urandom_range(0, 3))
                                                      : 8'($urandom));
                3: mem_access(16'($urandom), 1'($urandom));
                default: collide(2'($urandom), 8'($urandom), 8'($urandom));
            endcase
        end

        // Reset during a pending SPI request.
        spi_write(2'd0, 8'h3C);
        @(negedge clk);
        bif.spi_wr_req  = 1'b1;
        bif.spi_wr_sel  = 2'd1;
        bif.spi_wr_data = 8'h5A;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_async", bif.bank_regs, model_regs());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_ack", 32'(bif.spi_wr_ack), 32'd0);
            check("reset_held_regs", bif.bank_regs, model_regs());
        end
        reset = 1'b0;
        @(negedge clk);
        m[1] = 8'h5A;
        check("post_reset_ack", 32'(bif.spi_wr_ack), 32'd1);
        check("post_reset_regs", bif.bank_regs, model_regs());
        bif.spi_wr_req = 1'b0;
        @(negedge clk);
        check("post_reset_ack_end", 32'(bif.spi_wr_ack), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
